// File: rtl/inst_rom_resp_pkg.sv
// Shared widths, constants and FSM encoding for the byte-serial instruction ROM responder.
// Also provides the byte-lane placement helper used for word assembly.
package inst_rom_resp_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int TAG_W       = INST_ADDR_W - 2;

  localparam logic              CHIP_ENABLE = 1'b1;
  localparam logic [INST_W-1:0] ZERO_WORD   = '0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  // Drop byte `b` into the lane selected by byte index and endianness.
  function automatic logic [INST_W-1:0] place_byte(
    input logic [INST_W-1:0] word,
    input logic [1:0]        idx,
    input logic [7:0]        b,
    input logic              le
  );
    logic [INST_W-1:0] r;
    logic [1:0]        lane;
    r    = word;
    lane = le ? idx : (2'd3 - idx);
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/inst_rom_resp_fetch_buf.sv
// One-entry instruction word buffer: tag/data/valid, hit compare and flush tracking.
// A flush seen while a fetch is in flight stays pending so that word is never marked valid.
module fetch_buf
  import inst_rom_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              busy,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [INST_W-1:0] fill_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [INST_W-1:0] hit_data
);

  logic [TAG_W-1:0]  tag_reg;
  logic [INST_W-1:0] data_reg;
  logic              valid_reg;
  logic              flush_pend_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_reg        <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      flush_pend_reg <= 1'b0;
    end else if (fill_en) begin
      tag_reg        <= fill_tag;
      data_reg       <= fill_data;
      valid_reg      <= !(flush || flush_pend_reg);
      flush_pend_reg <= 1'b0;
    end else begin
      if (flush) begin
        valid_reg <= 1'b0;
      end
      if (flush && busy) begin
        flush_pend_reg <= 1'b1;
      end
    end
  end

  assign hit      = valid_reg && (tag_reg == lookup_tag);
  assign hit_data = data_reg;

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction ROM responder: serves 32-bit words from a one-entry buffer and refills it
// from an 8-bit external memory, one byte request outstanding at a time.
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ENDIAN_LE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  output logic [INST_W-1:0]      rom_data_o,
  output logic                   rom_stall_o,
  input  logic                   flush_i,
  output logic                   mem_re_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic [7:0]             mem_data_i,
  input  logic                   mem_valid_i
);

  fetch_state_e      state_reg;
  logic [1:0]        byte_idx_reg;
  logic [TAG_W-1:0]  line_tag_reg;
  logic [INST_W-1:0] asm_reg;

  logic              hit;
  logic [INST_W-1:0] hit_data;
  logic              serve;
  logic              miss;
  logic              fill_en;
  logic [INST_W-1:0] asm_next;
  logic [INST_ADDR_W-1:0] first_addr;
  logic [INST_ADDR_W-1:0] step_addr;
  logic              unused_bits;

  assign serve   = rst && (rom_ce_i == CHIP_ENABLE);
  assign miss    = serve && !hit;
  assign fill_en = (state_reg == ST_FETCH) && mem_valid_i && (byte_idx_reg == 2'd3);

  assign asm_next   = place_byte(asm_reg, byte_idx_reg, mem_data_i, ENDIAN_LE != 0);
  assign first_addr = {rom_addr_i[INST_ADDR_W-1:2], 2'b00};
  assign step_addr  = {line_tag_reg, byte_idx_reg + 2'd1};

  assign rom_stall_o = miss;
  assign rom_data_o  = (serve && hit) ? hit_data : ZERO_WORD;

  // Byte lane of the CPU address and any bits above ADDR_W are intentionally dropped.
  assign unused_bits = ^{rom_addr_i[1:0], first_addr, step_addr};

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_i),
    .busy       (state_reg == ST_FETCH),
    .fill_en    (fill_en),
    .fill_tag   (line_tag_reg),
    .fill_data  (asm_next),
    .lookup_tag (rom_addr_i[INST_ADDR_W-1:2]),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  // The memory request is registered: it is set up on the edge that enters or advances
  // FETCH, so it stays stable across wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      byte_idx_reg <= 2'd0;
      line_tag_reg <= '0;
      asm_reg      <= '0;
      mem_re_o     <= 1'b0;
      mem_addr_o   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (miss) begin
            line_tag_reg <= rom_addr_i[INST_ADDR_W-1:2];
            byte_idx_reg <= 2'd0;
            asm_reg      <= '0;
            mem_re_o     <= 1'b1;
            mem_addr_o   <= first_addr[ADDR_W-1:0];
            state_reg    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_valid_i) begin
            asm_reg <= asm_next;
            if (byte_idx_reg == 2'd3) begin
              byte_idx_reg <= 2'd0;
              mem_re_o     <= 1'b0;
              state_reg    <= ST_IDLE;
            end else begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
              mem_addr_o   <= step_addr[ADDR_W-1:0];
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          mem_re_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_rom_resp.md
INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 Parameter ADDR_W, default 16, sets the external byte-address width.
REQ-002 Parameter ENDIAN_LE, default 1, selects little-endian byte assembly; 0 selects big-endian.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rom_ce_i  input  1  fetch enable from pc_reg side (`ChipEnable).
REQ-006 rom_addr_i  input  32 (`InstAddrBus)  instruction byte address; bits [1:0] ignored.
REQ-007 rom_data_o  output  32 (`InstBus)  instruction word returned to the IF/ID stage.
REQ-008 rom_stall_o  output  1  high while the requested word is not yet available.
REQ-009 flush_i  input  1  invalidate the word buffer.
REQ-010 mem_re_o  output  1  byte read request to external memory.
REQ-011 mem_addr_o  output  ADDR_W  external byte address.
REQ-012 mem_data_i  input  8  read byte.
REQ-013 mem_valid_i  input  1  byte accepted/returned this cycle; may assert in the same cycle as mem_re_o.

Function
REQ-014 One-entry buffer holds tag (addr[31:2]), 32-bit data and a valid bit.
REQ-015 Hit: rom_ce_i=1, valid=1 and rom_addr_i[31:2]==tag -> rom_data_o=buffer data and rom_stall_o=0, combinationally in that cycle.
REQ-016 rom_ce_i=0 -> rom_data_o=`ZeroWord and rom_stall_o=0, regardless of state.
REQ-017 Miss: rom_ce_i=1 and no hit -> rom_stall_o=1 combinationally; in IDLE, latch addr[31:2] and enter FETCH on the next edge.
REQ-018 FSM states: IDLE, FETCH. FETCH returns to IDLE after byte 3 is accepted.
REQ-019 FETCH issues byte index k=0..3 in order: mem_re_o=1 and mem_addr_o={latched addr, k} truncated to ADDR_W bits.
REQ-020 mem_re_o and mem_addr_o hold steady until mem_valid_i=1; k advances only on mem_valid_i.
REQ-021 With ENDIAN_LE=1, byte k lands in data[8k+7:8k]; with ENDIAN_LE=0, it lands in data[31-8k:24-8k].
REQ-022 On acceptance of byte 3: tag<=latched addr, data<=assembled word, valid<=1, state<=IDLE; the hit is served on the following cycle.
REQ-023 Zero-wait memory gives a miss-to-data latency of 5 stall cycles, with data valid in the 6th cycle.
REQ-024 Changes to rom_addr_i or rom_ce_i during FETCH do not abort the fetch; the word completes, then the current request is re-evaluated against the buffer.
REQ-025 flush_i=1 clears valid on the next edge; if in FETCH, the in-flight word is still fetched but valid is not set at completion (flush is sticky until then).
REQ-026 flush_i together with byte-3 acceptance in the same cycle -> valid=0.
REQ-027 mem_re_o=0 in IDLE; at most one byte request is outstanding.

Reset
REQ-028 rst=0 asynchronously forces state=IDLE, k=0, valid=0, tag=0, data=0, mem_re_o=0, mem_addr_o=0, and the pending-flush flag to 0.
REQ-029 While rst=0, rom_data_o=`ZeroWord and rom_stall_o=0.
REQ-030 Reset asserted mid-FETCH discards partial bytes; after release, the first rom_ce_i=1 request is a miss.

Structure
REQ-031 Bus widths, `ChipEnable, `ZeroWord and FSM state encodings live in defines.v; no local width literals for CPU-side buses.
REQ-032 The buffer (tag/data/valid, hit compare, flush handling) is one sub-module, fetch_buf; the FSM and byte sequencing live in inst_rom_resp.
REQ-033 One always block drives registered state; combinational outputs are computed in separate logic.

Verification
REQ-034 Cold miss: rst release, rom_ce_i=1, addr=0x0000_0010, memory bytes 0x13,0x05,0x10,0x00, zero wait -> stall high 5 cycles, mem_addr_o 0x10..0x13, then rom_data_o=0x0010_0513 with stall=0.
REQ-035 Hit: repeat addr 0x10, then 0x12 -> no mem_re_o, stall=0, data=0x0010_0513 both cycles.
REQ-036 Wait states: mem_valid_i delayed 2 cycles per byte -> mem_addr_o and mem_re_o stable during waits; 13 stall cycles; correct word.
REQ-037 Flush mid-fetch: flush_i pulse during byte 1 -> fetch completes, valid stays 0, and a second full miss sequence follows.
REQ-038 rom_ce_i=0 -> rom_data_o=0x0000_0000 and stall=0 in IDLE and in FETCH.
REQ-039 Reset mid-fetch: rst low during byte 2 -> mem_re_o=0 immediately; after release, the same address re-fetches all 4 bytes from k=0.
